// File: rtl/cdb_broadcast_arbiter_if.sv
// FU <-> CDB arbiter handshake bundle. master = functional-unit side, slave = arbiter.
// An FU holds i_fu_ready and its payload stable until it sees its o_fu_broadcast_en bit, and
// it is consumed in that grant cycle. o_cdb_valid is a one-cycle pulse with no backpressure.
interface cdb_broadcast_arbiter_if #(
  parameter int NUM_FU  = 4,
  parameter int ROBSIZE = 8
);
  localparam int ID_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0]         i_fu_ready;
  logic [NUM_FU*32-1:0]      i_fu_data;
  logic [NUM_FU*ROBSIZE-1:0] i_fu_rob_addr;
  logic [NUM_FU-1:0]         i_fu_addr_cal;
  logic [NUM_FU-1:0]         i_fu_con_branch_comp;
  logic [NUM_FU-1:0]         o_fu_broadcast_en;
  logic                      o_cdb_valid;
  logic [31:0]               o_cdb_data;
  logic [ROBSIZE-1:0]        o_cdb_rob_addr;
  logic                      o_cdb_addr_cal;
  logic                      o_cdb_con_branch_comp;
  logic [ID_W-1:0]           o_cdb_fu_id;

  modport master (
    output i_fu_ready, i_fu_data, i_fu_rob_addr, i_fu_addr_cal, i_fu_con_branch_comp,
    input  o_fu_broadcast_en, o_cdb_valid, o_cdb_data, o_cdb_rob_addr,
           o_cdb_addr_cal, o_cdb_con_branch_comp, o_cdb_fu_id
  );

  modport slave (
    input  i_fu_ready, i_fu_data, i_fu_rob_addr, i_fu_addr_cal, i_fu_con_branch_comp,
    output o_fu_broadcast_en, o_cdb_valid, o_cdb_data, o_cdb_rob_addr,
           o_cdb_addr_cal, o_cdb_con_branch_comp, o_cdb_fu_id
  );
endinterface

// File: rtl/cdb_broadcast_arbiter.sv
// Grants one FU per cycle onto the common data bus; registered grant, registered CDB entry.
// Build option CDB_ARB_FIXED_PRIO_EN: lowest-index requester wins instead of round-robin.
module cdb_broadcast_arbiter #(
  parameter int NUM_FU  = 4,
  parameter int ROBSIZE = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_flush,
  cdb_broadcast_arbiter_if.slave  io_bus
);
  localparam int ID_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0]  r_grant;
  logic [ID_W-1:0]    r_grant_idx;
  logic               r_cdb_valid;
  logic [31:0]        r_cdb_data;
  logic [ROBSIZE-1:0] r_cdb_rob_addr;
  logic               r_cdb_addr_cal;
  logic               r_cdb_con_branch_comp;
  logic [ID_W-1:0]    r_cdb_fu_id;

  logic [NUM_FU-1:0]  w_req;
  logic [NUM_FU-1:0]  w_grant_nxt;
  logic [ID_W-1:0]    w_sel_idx;
  logic               w_found;
`ifndef CDB_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    w_ptr_nxt;
`endif

  // The FU granted last cycle may still show ready while it reacts; never grant it twice.
  assign w_req = io_bus.i_fu_ready & ~r_grant;

  always_comb begin : p_select
    logic [ID_W-1:0] v_idx;
`ifndef CDB_ARB_FIXED_PRIO_EN
    logic [ID_W:0]   v_sum;
    v_sum = '0;
`endif
    w_found     = 1'b0;
    w_sel_idx   = '0;
    w_grant_nxt = '0;
    v_idx       = '0;
    for (int i = 0; i < NUM_FU; i++) begin
`ifdef CDB_ARB_FIXED_PRIO_EN
      v_idx = ID_W'(i);
`else
      v_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
      if (v_sum >= (ID_W+1)'(NUM_FU)) v_sum = v_sum - (ID_W+1)'(NUM_FU);
      v_idx = v_sum[ID_W-1:0];
`endif
      if (!w_found && w_req[v_idx]) begin
        w_found   = 1'b1;
        w_sel_idx = v_idx;
      end
    end
    if (w_found) w_grant_nxt[w_sel_idx] = 1'b1;
  end

`ifndef CDB_ARB_FIXED_PRIO_EN
  assign w_ptr_nxt = (w_sel_idx == ID_W'(NUM_FU-1)) ? '0 : w_sel_idx + 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_grant               <= '0;
      r_grant_idx           <= '0;
`ifndef CDB_ARB_FIXED_PRIO_EN
      r_rr_ptr              <= '0;
`endif
      r_cdb_valid           <= 1'b0;
      r_cdb_data            <= '0;
      r_cdb_rob_addr        <= '0;
      r_cdb_addr_cal        <= 1'b0;
      r_cdb_con_branch_comp <= 1'b0;
      r_cdb_fu_id           <= '0;
    end else if (i_flush) begin
      // A grant issued this cycle is dropped: no capture, pointer untouched.
      r_grant     <= '0;
      r_cdb_valid <= 1'b0;
    end else begin
      r_grant     <= w_grant_nxt;
      r_grant_idx <= w_sel_idx;
`ifndef CDB_ARB_FIXED_PRIO_EN
      if (w_found) r_rr_ptr <= w_ptr_nxt;
`endif
      r_cdb_valid <= |r_grant;
      if (|r_grant) begin
        r_cdb_data            <= io_bus.i_fu_data[r_grant_idx*32 +: 32];
        r_cdb_rob_addr        <= io_bus.i_fu_rob_addr[r_grant_idx*ROBSIZE +: ROBSIZE];
        r_cdb_addr_cal        <= io_bus.i_fu_addr_cal[r_grant_idx];
        r_cdb_con_branch_comp <= io_bus.i_fu_con_branch_comp[r_grant_idx];
        r_cdb_fu_id           <= r_grant_idx;
      end
    end
  end

  assign io_bus.o_fu_broadcast_en     = r_grant;
  assign io_bus.o_cdb_valid           = r_cdb_valid;
  assign io_bus.o_cdb_data            = r_cdb_data;
  assign io_bus.o_cdb_rob_addr        = r_cdb_rob_addr;
  assign io_bus.o_cdb_addr_cal        = r_cdb_addr_cal;
  assign io_bus.o_cdb_con_branch_comp = r_cdb_con_branch_comp;
  assign io_bus.o_cdb_fu_id           = r_cdb_fu_id;

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Bench for cdb_broadcast_arbiter: directed handshake scenarios, then random FU traffic
// against a cycle-level reference model of the arbitration rules.
module tb_cdb_broadcast_arbiter;
  localparam int NUM_FU  = 4;
  localparam int ROBSIZE = 8;
  localparam int ID_W    = 2;
  localparam int ENT_W   = ID_W + 2 + ROBSIZE + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  logic i_flush;
  always #5 clk = ~clk;

  cdb_broadcast_arbiter_if #(.NUM_FU(NUM_FU), .ROBSIZE(ROBSIZE)) bus ();

  cdb_broadcast_arbiter #(.NUM_FU(NUM_FU), .ROBSIZE(ROBSIZE)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_flush (i_flush),
    .io_bus  (bus.slave)
  );

  // ---------------- FU-side stimulus state ----------------
  logic               fu_rdy  [NUM_FU];
  logic [31:0]        fu_dat  [NUM_FU];
  logic [ROBSIZE-1:0] fu_rob  [NUM_FU];
  logic               fu_ac   [NUM_FU];
  logic               fu_bc   [NUM_FU];
  logic               fu_done [NUM_FU];

  for (genvar k = 0; k < NUM_FU; k++) begin : g_pack
    assign bus.i_fu_ready[k]                        = fu_rdy[k];
    assign bus.i_fu_data[32*k +: 32]                = fu_dat[k];
    assign bus.i_fu_rob_addr[ROBSIZE*k +: ROBSIZE]  = fu_rob[k];
    assign bus.i_fu_addr_cal[k]                     = fu_ac[k];
    assign bus.i_fu_con_branch_comp[k]              = fu_bc[k];
  end

  // ---------------- reference model + scoreboard ----------------
  int              m_grant;   // FU holding broadcast_en after the edge, -1 for none
  int              m_ptr;     // next FU to favour; stays 0 in the fixed-priority build
  bit              m_valid;
  logic [ENT_W-1:0] exp_q[$];
  logic [ENT_W-1:0] last_cdb;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    int win;
    int k;
    if (!rstn) begin
      m_grant  = -1;
      m_ptr    = 0;
      m_valid  = 1'b0;
      last_cdb = '0;
      exp_q.delete();
    end else if (i_flush) begin
      m_grant = -1;
      m_valid = 1'b0;
      exp_q.delete();
    end else begin
      m_valid = (m_grant >= 0);
      if (m_valid)
        exp_q.push_back({ID_W'(m_grant), fu_bc[m_grant], fu_ac[m_grant],
                         fu_rob[m_grant], fu_dat[m_grant]});
      win = -1;
      for (int i = 0; i < NUM_FU; i++) begin
        k = (m_ptr + i) % NUM_FU;
        if (win < 0 && fu_rdy[k] && k != m_grant) win = k;
      end
      m_grant = win;
`ifndef CDB_ARB_FIXED_PRIO_EN
      if (win >= 0) m_ptr = (win + 1) % NUM_FU;
`endif
    end
  endtask

  task automatic compare_all();
    logic [NUM_FU-1:0] exp_en;
    exp_en = '0;
    if (m_grant >= 0) exp_en[m_grant] = 1'b1;
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL scoreboard: expected queue empty on valid cycle");
      end else begin
        last_cdb = exp_q.pop_front();
      end
    end
    check("grant", 48'(bus.o_fu_broadcast_en), 48'(exp_en));
    check("valid", 48'(bus.o_cdb_valid), 48'(m_valid));
    check("data",  48'(bus.o_cdb_data), 48'(last_cdb[31:0]));
    check("rob",   48'(bus.o_cdb_rob_addr), 48'(last_cdb[32 +: ROBSIZE]));
    check("flags", 48'({bus.o_cdb_con_branch_comp, bus.o_cdb_addr_cal}),
                   48'(last_cdb[32+ROBSIZE +: 2]));
    check("fu_id", 48'(bus.o_cdb_fu_id), 48'(last_cdb[ENT_W-1 -: ID_W]));
  endtask

  // One clock: model consumes the inputs driven this cycle, DUT sampled 1ns after the edge.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_fu(input int k, input logic rdy, input logic [31:0] d,
                        input logic [ROBSIZE-1:0] r, input logic ac, input logic bc);
    fu_rdy[k] = rdy; fu_dat[k] = d; fu_rob[k] = r; fu_ac[k] = ac; fu_bc[k] = bc;
  endtask

  task automatic clear_fus();
    for (int k = 0; k < NUM_FU; k++) begin
      fu_rdy[k] = 1'b0; fu_done[k] = 1'b0;
    end
  endtask

  // Protocol-following FU behaviour driven by the model's grant.
  task automatic fu_react(input int ready_pct);
    for (int k = 0; k < NUM_FU; k++) begin
      if (k == m_grant) begin
        fu_done[k] = 1'b1;
        if ($urandom_range(0, 1) == 1) fu_rdy[k] = 1'b0;
      end else if (fu_done[k]) begin
        fu_rdy[k]  = 1'b0;
        fu_done[k] = 1'b0;
      end else if (!fu_rdy[k] && $urandom_range(0, 99) < ready_pct) begin
        set_fu(k, 1'b1, $urandom(), ROBSIZE'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (fu_rdy[k] && $urandom_range(0, 99) < 3) begin
        fu_rdy[k] = 1'b0;
      end
    end
  endtask

  // ---------------- test sequence ----------------
  logic [NUM_FU-1:0] wrap_seq [4];

  initial begin
    rstn = 1'b0; i_flush = 1'b0;
    m_grant = -1; m_ptr = 0; m_valid = 1'b0; last_cdb = '0;
    for (int k = 0; k < NUM_FU; k++) set_fu(k, 1'b0, '0, '0, 1'b0, 1'b0);
    clear_fus();
    #2;
    step();
    step();
    check("reset_en", 48'(bus.o_fu_broadcast_en), 48'h0);
    check("reset_valid", 48'(bus.o_cdb_valid), 48'h0);
    rstn = 1'b1;

    // Single request from FU2
    set_fu(2, 1'b1, 32'h8, 8'h02, 1'b1, 1'b0);
    step();
    check("single_en", 48'(bus.o_fu_broadcast_en), 48'h4);
    fu_rdy[2] = 1'b0;
    step();
    check("single_valid", 48'(bus.o_cdb_valid), 48'h1);
    check("single_data", 48'(bus.o_cdb_data), 48'h8);
    check("single_rob", 48'(bus.o_cdb_rob_addr), 48'h02);
    check("single_ac", 48'(bus.o_cdb_addr_cal), 48'h1);
    check("single_id", 48'(bus.o_cdb_fu_id), 48'h2);
    step();

    // Contention FU0/1/3 from a freshly reset pointer
    rstn = 1'b0; step(); rstn = 1'b1;
    set_fu(0, 1'b1, 32'hA0, 8'h10, 1'b0, 1'b1);
    set_fu(1, 1'b1, 32'hA1, 8'h11, 1'b1, 1'b0);
    set_fu(3, 1'b1, 32'hA3, 8'h13, 1'b0, 1'b0);
    step();
    check("cont_en0", 48'(bus.o_fu_broadcast_en), 48'h1);
    fu_rdy[0] = 1'b0;
    step();
    check("cont_en1", 48'(bus.o_fu_broadcast_en), 48'h2);
    check("cont_rob0", 48'(bus.o_cdb_rob_addr), 48'h10);
    fu_rdy[1] = 1'b0;
    step();
    check("cont_en3", 48'(bus.o_fu_broadcast_en), 48'h8);
    check("cont_rob1", 48'(bus.o_cdb_rob_addr), 48'h11);
    fu_rdy[3] = 1'b0;
    step();
    check("cont_rob3", 48'(bus.o_cdb_rob_addr), 48'h13);
    check("cont_idle", 48'(bus.o_fu_broadcast_en), 48'h0);

    // Wrap/fairness: FU2 first moves the pointer to 3, then FU0+FU3 hold ready
    set_fu(2, 1'b1, 32'hB2, 8'h22, 1'b0, 1'b0);
    step();
    fu_rdy[2] = 1'b0;
    set_fu(0, 1'b1, 32'hB0, 8'h20, 1'b1, 1'b1);
    set_fu(3, 1'b1, 32'hB3, 8'h23, 1'b1, 1'b0);
`ifdef CDB_ARB_FIXED_PRIO_EN
    wrap_seq[0] = 4'b0001; wrap_seq[1] = 4'b1000; wrap_seq[2] = 4'b0001; wrap_seq[3] = 4'b1000;
`else
    wrap_seq[0] = 4'b1000; wrap_seq[1] = 4'b0001; wrap_seq[2] = 4'b1000; wrap_seq[3] = 4'b0001;
`endif
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("wrap_en%0d", i), 48'(bus.o_fu_broadcast_en), 48'(wrap_seq[i]));
    end
    fu_rdy[0] = 1'b0; fu_rdy[3] = 1'b0;
    step();
    step();

    // Flush in the grant cycle
    set_fu(1, 1'b1, 32'hC1, 8'h31, 1'b0, 1'b0);
    step();
    check("flush_pre_en", 48'(bus.o_fu_broadcast_en), 48'h2);
    fu_rdy[1] = 1'b0;
    i_flush = 1'b1;
    step();
    check("flush_en", 48'(bus.o_fu_broadcast_en), 48'h0);
    check("flush_valid", 48'(bus.o_cdb_valid), 48'h0);
    i_flush = 1'b0;
    step();
    check("flush_post_valid", 48'(bus.o_cdb_valid), 48'h0);

    // Reset in the grant cycle, then FU0 vs FU2 from pointer 0
    set_fu(0, 1'b1, 32'hD0, 8'h40, 1'b1, 1'b0);
    step();
    check("rst_pre_en", 48'(bus.o_fu_broadcast_en), 48'h1);
    rstn = 1'b0;
    step();
    check("rst_en", 48'(bus.o_fu_broadcast_en), 48'h0);
    check("rst_valid", 48'(bus.o_cdb_valid), 48'h0);
    check("rst_data", 48'(bus.o_cdb_data), 48'h0);
    rstn = 1'b1;
    set_fu(2, 1'b1, 32'hD2, 8'h42, 1'b0, 1'b0);
    step();
    check("rst_post_en", 48'(bus.o_fu_broadcast_en), 48'h1);
    clear_fus();
    step();
    step();

    // Random traffic with occasional flush and reset
    for (int c = 0; c < 3000; c++) begin
      i_flush = ($urandom_range(0, 99) < 2);
      if (!rstn) rstn = 1'b1;
      else if ($urandom_range(0, 999) < 5) rstn = 1'b0;
      step();
      fu_react((c < 1500) ? 60 : 20);
    end
    i_flush = 1'b0;
    clear_fus();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
